cnn_multifilter_engine: RTL and testbench
=========================================

// Module: cnn_multifilter_engine
// PURPOSE
// - Next-gen CNN top: conv -> maxpool per filter over NUM_FILTERS kernels on one ifmap, then concatenate pooled maps into one feature vector.
// - Feature vector feeds a serial (1 MAC/cycle) fully-connected layer, then an optional argmax.
// - Reuses existing conv / maxpool from cnn_defs.svh; owns sequencing FSM, feature buffer, FC datapath, start/busy/done handshake.
// PARAMETERS
// - NUM_FILTERS  4              conv kernels applied in sequence, >=1
// - N_CLASSES    NUM_CLASSES    FC outputs, >=2
// - ACC_WIDTH    FC_MAC_WIDTH   FC accumulator/output width, signed
// - FEAT_LEN     NUM_FILTERS*POOL_PIXEL_COUNT  (derived localparam, not overridable)
// PORTS
// - clk         in   1                                clock, rising edge
// - reset       in   1                                async, active-high
// - start       in   1                                1-cycle pulse, accepted only in IDLE
// - cnn_ifmap   in   DATA_WIDTH x IFMAP_SIZE^2         unsigned pixels, held stable while busy
// - weights     in   DATA_WIDTH x NUM_FILTERS x K^2    signed conv kernels
// - fc_weights  in   DATA_WIDTH x N_CLASSES x FEAT_LEN signed
// - fc_bias     in   FC_BIAS_WIDTH x N_CLASSES         signed
// - feat_out    out  DATA_WIDTH x FEAT_LEN             feature buffer, filter f at [f*POOL_PIXEL_COUNT +: POOL_PIXEL_COUNT]
// - fc_out      out  ACC_WIDTH x N_CLASSES             signed logits, registered
// - class_idx   out  $clog2(N_CLASSES)                 argmax result
// - busy        out  1                                 high from cycle after accepted start until done
// - done        out  1                                 1-cycle pulse, run complete
// BEHAVIOUR
// - Reset (async): FSM=IDLE; feat_out, fc_out, class_idx, filt_cnt, cls_cnt, feat_cnt, accumulator = 0; busy=done=0; reset also drives conv/maxpool reset.
// - FSM: IDLE -start-> CONV -> POOL -> STORE -> (filt_cnt<NUM_FILTERS-1 ? CONV : FC_INIT) -> FC_MAC -> (ARGMAX) -> DONE -> IDLE.
// - CONV: conv en held high, kernel = weights[filt_cnt]; maxpool en = conv_done; leave CONV when conv_done observed.
// - POOL: wait for pool_done; en to conv deasserted.
// - STORE: single cycle, copy flattened pool_ofmap (row-major) into feat_out slice filt_cnt; filt_cnt++.
// - FC_INIT: acc = sign-extended fc_bias[cls_cnt]; feat_cnt=0.
// - FC_MAC: each cycle acc += $signed({1'b0,feat_out[feat_cnt]}) * fc_weights[cls_cnt][feat_cnt]; product 2*DATA_WIDTH+1 bits, sign-extended to ACC_WIDTH; overflow wraps (two's complement). At feat_cnt==FEAT_LEN-1: write final sum to a shadow register for cls_cnt; if cls_cnt<N_CLASSES-1, reload bias for next class in same cycle (no bubble), else exit.
// - FC latency: exactly N_CLASSES*FEAT_LEN cycles in FC_MAC, +1 for FC_INIT.
// - fc_out is updated atomically from the shadow register on entry to DONE; holds previous run values during a run.
// - feat_out is updated progressively (slice f is valid after STORE of filter f).
// - busy=1 in all states except IDLE; done=1 only in DONE (one cycle), busy drops the same cycle FSM returns to IDLE.
// - start while busy: ignored, no queuing. start in the DONE cycle: ignored.
// - Reset mid-run: immediate abort to IDLE, all outputs cleared; no done pulse.
// - NUM_FILTERS==1: STORE goes directly to FC_INIT.
// CONFIGURATION
// - CNN_ARGMAX_EN defined: ARGMAX state scans shadow logits one class per cycle (N_CLASSES cycles); strict '>' compare, so ties resolve to lowest index; class_idx registered on entry to DONE.
// - CNN_ARGMAX_EN undefined: ARGMAX state and comparator not built; FC_MAC -> DONE; class_idx tied 0; total latency N_CLASSES cycles shorter.
// TESTING
// - Zero ifmap, bias={5,-3,7,0,...}, start -> feat_out all 0, fc_out==bias, class_idx==2 (ARGMAX_EN), single done pulse.
// - Two equal max biases at classes 1 and 4, zero features -> class_idx==1 (tie -> lowest).
// - Ifmap all 1, filter f kernel = centre tap f+1, others 0 -> slice f of feat_out all (f+1); fc_weights all 1, bias 0 -> each fc_out == POOL_PIXEL_COUNT*(1+2+3+4).
// - Feature 255, weight -128 everywhere -> fc_out == -32640*FEAT_LEN (sign handling of unsigned*signed).
// - start pulsed again at CONV of filter 2 -> ignored; exactly one done; cycle count start->done matches formula.
// - Assert reset during FC_MAC -> busy=0, fc_out=0, no done; following start completes normally with correct fc_out.

Source files
------------

// File: rtl/cnn_multifilter_engine.sv
// ---------------------------------------------------------------------------
// cnn_multifilter_engine
//   Runs NUM_FILTERS conv -> 2x2 maxpool passes over one input feature map,
//   concatenates the pooled maps into a feature vector, feeds that through a
//   serial (one MAC per cycle) fully-connected layer and optionally picks the
//   winning class.
//
//   Optional feature macro: CNN_ARGMAX_EN
//     defined   : ARGMAX state scans the logits one class per cycle
//     undefined : no ARGMAX state, class_idx tied to 0
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   start      one-cycle pulse, accepted only in IDLE
//   cnn_ifmap  DATA_WIDTH x IFMAP_SIZE^2 unsigned pixels, held while busy
//   weights    DATA_WIDTH x NUM_FILTERS x K^2 signed conv kernels
//   fc_weights DATA_WIDTH x N_CLASSES x FEAT_LEN signed
//   fc_bias    FC_BIAS_WIDTH x N_CLASSES signed
//   feat_out   feature buffer, filter f at [f*POOL_PIXEL_COUNT +: POOL_PIXEL_COUNT]
//   fc_out     ACC_WIDTH x N_CLASSES signed logits
//   class_idx  argmax result
//   busy       high in every state except IDLE
//   done       one-cycle pulse in DONE
//
// FSM states
//   state     | meaning
//   IDLE      | waiting for start
//   CONV      | conv running on kernel filt_cnt
//   POOL      | maxpool running on the conv output
//   STORE     | pooled map copied into feat_out slice filt_cnt
//   FC_INIT   | accumulator loaded with bias of class 0
//   FC_MAC    | one multiply-accumulate per cycle over all classes
//   ARGMAX    | logits scanned one per cycle (CNN_ARGMAX_EN only)
//   DONE      | fc_out/class_idx just updated, done pulse
// ---------------------------------------------------------------------------

// Valid (no padding, stride 1) convolution, one output pixel per cycle while
// en is high. Each result is clamped to 0..2^DATA_WIDTH-1 (ReLU + saturate).
module cnn_conv #(
    parameter int DATA_WIDTH = 8,
    parameter int IFMAP_SIZE = 6,
    parameter int K          = 3
) (
    input  logic                                                          clk,
    input  logic                                                          reset,
    input  logic                                                          en,
    input  logic [DATA_WIDTH*IFMAP_SIZE*IFMAP_SIZE-1:0]                   ifmap,
    input  logic [DATA_WIDTH*K*K-1:0]                                     kernel,
    output logic [DATA_WIDTH*(IFMAP_SIZE-K+1)*(IFMAP_SIZE-K+1)-1:0]       ofmap,
    output logic                                                          done
);
    localparam int OUT = IFMAP_SIZE - K + 1;
    localparam int OW  = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int PW  = 2*DATA_WIDTH + 1;
    localparam int SW  = PW + $clog2(K*K) + 1;
    localparam logic [OW-1:0]        LAST    = OW'(OUT - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << DATA_WIDTH) - 1);

    logic [OW-1:0]          row, col;
    logic                   fin;
    logic signed [PW-1:0]   prod;
    logic signed [SW-1:0]   sum;
    logic [DATA_WIDTH-1:0]  pix;

    always_comb begin
        sum  = '0;
        prod = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod = $signed({1'b0, ifmap[((int'(row) + i) * IFMAP_SIZE + int'(col) + j) * DATA_WIDTH +: DATA_WIDTH]})
                     * $signed(kernel[(i * K + j) * DATA_WIDTH +: DATA_WIDTH]);
                sum  = sum + SW'(prod);
            end
        end
        if (sum[SW-1])          pix = '0;
        else if (sum > SAT_MAX) pix = '1;
        else                    pix = sum[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row   <= '0;
            col   <= '0;
            fin   <= 1'b0;
            ofmap <= '0;
        end else if (!en) begin
            row <= '0;
            col <= '0;
            fin <= 1'b0;
        end else if (!fin) begin
            ofmap[(int'(row) * OUT + int'(col)) * DATA_WIDTH +: DATA_WIDTH] <= pix;
            if (col == LAST) begin
                col <= '0;
                if (row == LAST) fin <= 1'b1;
                else             row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Gated with en so the pool sees a single-cycle start.
    assign done = fin & en;
endmodule

// 2x2 stride-2 maxpool, one output pixel per cycle; launched by en in idle.
module cnn_maxpool #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_SIZE    = 4
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  en,
    input  logic [DATA_WIDTH*IN_SIZE*IN_SIZE-1:0]                 ifmap,
    output logic [DATA_WIDTH*(IN_SIZE/2)*(IN_SIZE/2)-1:0]         ofmap,
    output logic                                                  done
);
    localparam int PO = IN_SIZE / 2;
    localparam int QW = (PO > 1) ? $clog2(PO) : 1;
    localparam logic [QW-1:0] LAST = QW'(PO - 1);

    logic [QW-1:0]         prow, pcol;
    logic                  run;
    logic [DATA_WIDTH-1:0] a, b, c, d, m0, m1, mx;
    int                    base;

    assign base = ((2 * int'(prow)) * IN_SIZE + 2 * int'(pcol)) * DATA_WIDTH;
    assign a  = ifmap[base +: DATA_WIDTH];
    assign b  = ifmap[base + DATA_WIDTH +: DATA_WIDTH];
    assign c  = ifmap[base + IN_SIZE*DATA_WIDTH +: DATA_WIDTH];
    assign d  = ifmap[base + (IN_SIZE+1)*DATA_WIDTH +: DATA_WIDTH];
    assign m0 = (a > b) ? a : b;
    assign m1 = (c > d) ? c : d;
    assign mx = (m0 > m1) ? m0 : m1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prow  <= '0;
            pcol  <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
            ofmap <= '0;
        end else begin
            done <= 1'b0;
            if (!run) begin
                if (en) begin
                    run  <= 1'b1;
                    prow <= '0;
                    pcol <= '0;
                end
            end else begin
                ofmap[(int'(prow) * PO + int'(pcol)) * DATA_WIDTH +: DATA_WIDTH] <= mx;
                if (pcol == LAST) begin
                    pcol <= '0;
                    if (prow == LAST) begin
                        run  <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        prow <= prow + 1'b1;
                    end
                end else begin
                    pcol <= pcol + 1'b1;
                end
            end
        end
    end
endmodule

module cnn_multifilter_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int IFMAP_SIZE    = 6,
    parameter int K             = 3,
    parameter int FC_BIAS_WIDTH = 16,
    parameter int NUM_CLASSES   = 5,
    parameter int FC_MAC_WIDTH  = 32,
    parameter int NUM_FILTERS   = 4,
    parameter int N_CLASSES     = NUM_CLASSES,
    parameter int ACC_WIDTH     = FC_MAC_WIDTH,
    localparam int CONV_OUT         = IFMAP_SIZE - K + 1,
    localparam int POOL_PIXEL_COUNT = (CONV_OUT / 2) * (CONV_OUT / 2),
    localparam int FEAT_LEN         = NUM_FILTERS * POOL_PIXEL_COUNT,
    localparam int CLS_W            = $clog2(N_CLASSES)
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [DATA_WIDTH*IFMAP_SIZE*IFMAP_SIZE-1:0]  cnn_ifmap,
    input  logic [DATA_WIDTH*NUM_FILTERS*K*K-1:0]        weights,
    input  logic [DATA_WIDTH*N_CLASSES*FEAT_LEN-1:0]     fc_weights,
    input  logic [FC_BIAS_WIDTH*N_CLASSES-1:0]           fc_bias,
    output logic [DATA_WIDTH*FEAT_LEN-1:0]               feat_out,
    output logic [ACC_WIDTH*N_CLASSES-1:0]               fc_out,
    output logic [CLS_W-1:0]                             class_idx,
    output logic                                         busy,
    output logic                                         done
);
    localparam int FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int FEAT_W = (FEAT_LEN > 1) ? $clog2(FEAT_LEN) : 1;
    localparam int PROD_W = 2*DATA_WIDTH + 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(NUM_FILTERS - 1);
    localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(FEAT_LEN - 1);
    localparam logic [CLS_W-1:0]  CLS_LAST  = CLS_W'(N_CLASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_POOL,
        S_STORE,
        S_FC_INIT,
        S_FC_MAC,
`ifdef CNN_ARGMAX_EN
        S_ARGMAX,
`endif
        S_DONE
    } state_t;

    state_t                                      state;
    logic [FILT_W-1:0]                           filt_cnt;
    logic [CLS_W-1:0]                            cls_cnt;
    logic [FEAT_W-1:0]                           feat_cnt;
    logic signed [ACC_WIDTH-1:0]                 acc;
    logic signed [ACC_WIDTH-1:0]                 shadow [N_CLASSES];
    logic [ACC_WIDTH*N_CLASSES-1:0]              shadow_next;
    logic                                        shadow_wr;

    logic                                        conv_en, conv_done, pool_done;
    logic [DATA_WIDTH*K*K-1:0]                   kernel;
    logic [DATA_WIDTH*CONV_OUT*CONV_OUT-1:0]     conv_ofmap;
    logic [DATA_WIDTH*POOL_PIXEL_COUNT-1:0]      pool_ofmap;

    logic [DATA_WIDTH-1:0]                       feat_sel;
    logic signed [DATA_WIDTH-1:0]                w_sel;
    logic signed [PROD_W-1:0]                    prod;
    logic signed [ACC_WIDTH-1:0]                 mac_sum;

    assign conv_en = (state == S_CONV);
    assign kernel  = weights[int'(filt_cnt) * K * K * DATA_WIDTH +: K * K * DATA_WIDTH];

    cnn_conv #(
        .DATA_WIDTH (DATA_WIDTH),
        .IFMAP_SIZE (IFMAP_SIZE),
        .K          (K)
    ) u_conv (
        .clk    (clk),
        .reset  (reset),
        .en     (conv_en),
        .ifmap  (cnn_ifmap),
        .kernel (kernel),
        .ofmap  (conv_ofmap),
        .done   (conv_done)
    );

    cnn_maxpool #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_SIZE    (CONV_OUT)
    ) u_pool (
        .clk    (clk),
        .reset  (reset),
        .en     (conv_done),
        .ifmap  (conv_ofmap),
        .ofmap  (pool_ofmap),
        .done   (pool_done)
    );

    function automatic logic signed [ACC_WIDTH-1:0] bias_of(input logic [CLS_W-1:0] c);
        return ACC_WIDTH'($signed(fc_bias[int'(c) * FC_BIAS_WIDTH +: FC_BIAS_WIDTH]));
    endfunction

    // Features are unsigned: a zero MSB keeps 255 from reading as -1.
    assign feat_sel = feat_out[int'(feat_cnt) * DATA_WIDTH +: DATA_WIDTH];
    assign w_sel    = fc_weights[(int'(cls_cnt) * FEAT_LEN + int'(feat_cnt)) * DATA_WIDTH +: DATA_WIDTH];
    assign prod     = $signed({1'b0, feat_sel}) * w_sel;
    assign mac_sum  = acc + ACC_WIDTH'(prod);

    // Logits including the one being written this cycle, so fc_out can be
    // loaded in the same edge as the final MAC.
    assign shadow_wr = (state == S_FC_MAC) && (feat_cnt == FEAT_LAST);
    always_comb begin
        shadow_next = '0;
        for (int i = 0; i < N_CLASSES; i++) begin
            shadow_next[i*ACC_WIDTH +: ACC_WIDTH] =
                (shadow_wr && (int'(cls_cnt) == i)) ? mac_sum : shadow[i];
        end
    end

`ifdef CNN_ARGMAX_EN
    logic signed [ACC_WIDTH-1:0] best_val;
    logic [CLS_W-1:0]            best_idx;
    logic                        better;

    // Strict compare: on a tie the earlier (lower) index is kept.
    assign better = (cls_cnt == '0) || (shadow[cls_cnt] > best_val);
`else
    assign class_idx = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            filt_cnt <= '0;
            cls_cnt  <= '0;
            feat_cnt <= '0;
            acc      <= '0;
            feat_out <= '0;
            fc_out   <= '0;
            for (int i = 0; i < N_CLASSES; i++) shadow[i] <= '0;
`ifdef CNN_ARGMAX_EN
            best_val  <= '0;
            best_idx  <= '0;
            class_idx <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CONV;
                        busy     <= 1'b1;
                        filt_cnt <= '0;
                        cls_cnt  <= '0;
                        feat_cnt <= '0;
                    end
                end
                S_CONV: begin
                    if (conv_done) state <= S_POOL;
                end
                S_POOL: begin
                    if (pool_done) state <= S_STORE;
                end
                S_STORE: begin
                    feat_out[int'(filt_cnt) * POOL_PIXEL_COUNT * DATA_WIDTH +: POOL_PIXEL_COUNT * DATA_WIDTH] <= pool_ofmap;
                    if (filt_cnt == FILT_LAST) begin
                        filt_cnt <= '0;
                        state    <= S_FC_INIT;
                    end else begin
                        filt_cnt <= filt_cnt + 1'b1;
                        state    <= S_CONV;
                    end
                end
                S_FC_INIT: begin
                    acc      <= bias_of(cls_cnt);
                    feat_cnt <= '0;
                    state    <= S_FC_MAC;
                end
                S_FC_MAC: begin
                    if (feat_cnt == FEAT_LAST) begin
                        shadow[cls_cnt] <= mac_sum;
                        feat_cnt        <= '0;
                        if (cls_cnt != CLS_LAST) begin
                            // Next class starts without a bubble.
                            cls_cnt <= cls_cnt + 1'b1;
                            acc     <= bias_of(cls_cnt + 1'b1);
                        end else begin
                            cls_cnt <= '0;
`ifdef CNN_ARGMAX_EN
                            state   <= S_ARGMAX;
`else
                            state   <= S_DONE;
                            done    <= 1'b1;
                            fc_out  <= shadow_next;
`endif
                        end
                    end else begin
                        acc      <= mac_sum;
                        feat_cnt <= feat_cnt + 1'b1;
                    end
                end
`ifdef CNN_ARGMAX_EN
                S_ARGMAX: begin
                    if (better) begin
                        best_val <= shadow[cls_cnt];
                        best_idx <= cls_cnt;
                    end
                    if (cls_cnt == CLS_LAST) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        fc_out    <= shadow_next;
                        class_idx <= better ? cls_cnt : best_idx;
                        cls_cnt   <= '0;
                    end else begin
                        cls_cnt <= cls_cnt + 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_multifilter_engine.sv
`timescale 1ns/1ps
module tb_cnn_multifilter_engine;
    localparam int DW  = 8;
    localparam int IMG = 6;
    localparam int K   = 3;
    localparam int BW  = 16;
    localparam int NC  = 5;
    localparam int AW  = 32;
    localparam int NF  = 4;
    localparam int CO  = IMG - K + 1;
    localparam int PO  = CO / 2;
    localparam int PPC = PO * PO;
    localparam int FL  = NF * PPC;
    localparam int CW  = $clog2(NC);
`ifdef CNN_ARGMAX_EN
    localparam int HAS_ARG = 1;
`else
    localparam int HAS_ARG = 0;
`endif
    // conv: one cycle per output pixel + done cycle; pool: one per pooled
    // pixel + done cycle; STORE one cycle.
    localparam int PER_FILT = (CO * CO + 1) + (PPC + 1) + 1;
    localparam int LATENCY  = NF * PER_FILT + 1 + NC * FL + HAS_ARG * NC;

    logic                    clk = 1'b0;
    logic                    reset, start;
    logic [DW*IMG*IMG-1:0]   cnn_ifmap;
    logic [DW*NF*K*K-1:0]    weights;
    logic [DW*NC*FL-1:0]     fc_weights;
    logic [BW*NC-1:0]        fc_bias;
    logic [DW*FL-1:0]        feat_out;
    logic [AW*NC-1:0]        fc_out;
    logic [CW-1:0]           class_idx;
    logic                    busy, done;

    typedef struct {
        logic [DW*FL-1:0] feat;
        logic [AW*NC-1:0] fc;
        int               cls;
    } exp_t;

    exp_t             sb[$];
    int               n_checks;
    int               n_pass;
    logic [AW*NC-1:0] prev_fc;
    int               bv[NC];

    cnn_multifilter_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cnn_ifmap  (cnn_ifmap),
        .weights    (weights),
        .fc_weights (fc_weights),
        .fc_bias    (fc_bias),
        .feat_out   (feat_out),
        .fc_out     (fc_out),
        .class_idx  (class_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint fc_el(input logic [AW*NC-1:0] v, input int k);
        return longint'($signed(v[k*AW +: AW]));
    endfunction

    function automatic exp_t model();
        exp_t e;
        int   conv[CO*CO];
        int   lg[NC];
        int   s, m, acc, best;
        e.feat = '0;
        e.fc   = '0;
        for (int f = 0; f < NF; f++) begin
            for (int r = 0; r < CO; r++) begin
                for (int c = 0; c < CO; c++) begin
                    s = 0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            s += int'(cnn_ifmap[((r+i)*IMG + c + j)*DW +: DW])
                               * int'($signed(weights[((f*K + i)*K + j)*DW +: DW]));
                    if (s < 0)   s = 0;
                    if (s > 255) s = 255;
                    conv[r*CO + c] = s;
                end
            end
            for (int pr = 0; pr < PO; pr++) begin
                for (int pc = 0; pc < PO; pc++) begin
                    m = 0;
                    for (int a = 0; a < 2; a++)
                        for (int b = 0; b < 2; b++)
                            if (conv[(2*pr + a)*CO + 2*pc + b] > m) m = conv[(2*pr + a)*CO + 2*pc + b];
                    e.feat[(f*PPC + pr*PO + pc)*DW +: DW] = DW'(m);
                end
            end
        end
        for (int k = 0; k < NC; k++) begin
            acc = int'($signed(fc_bias[k*BW +: BW]));
            for (int i = 0; i < FL; i++)
                acc += int'(e.feat[i*DW +: DW]) * int'($signed(fc_weights[(k*FL + i)*DW +: DW]));
            lg[k] = acc;
            e.fc[k*AW +: AW] = acc;
        end
        best = 0;
        if (HAS_ARG != 0)
            for (int k = 1; k < NC; k++)
                if (lg[k] > lg[best]) best = k;
        e.cls = best;
        return e;
    endfunction

    task automatic set_bias();
        for (int k = 0; k < NC; k++) fc_bias[k*BW +: BW] = BW'(bv[k]);
    endtask

    task automatic run_case(input string name, input int again_at, input int abort_at);
        exp_t e;
        int   n, dones;
        bit   seen;
        e = model();
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, ".busy_start"}, busy, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < LATENCY + 50) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (n == 10)
                    for (int k = 0; k < NC; k++)
                        check({name, ".fc_hold"}, fc_el(fc_out, k), fc_el(prev_fc, k));
                if (n == again_at) start = 1'b1;
                if (n == abort_at) break;
                @(posedge clk);
                #1;
                n++;
                start = 1'b0;
            end
        end
        if (abort_at >= 0 && !seen) begin
            reset = 1'b1;
            #1;
            check({name, ".abort_busy"}, busy, 0);
            check({name, ".abort_done"}, done, 0);
            check({name, ".abort_feat"}, longint'(feat_out != '0), 0);
            for (int k = 0; k < NC; k++)
                check({name, ".abort_fc"}, fc_el(fc_out, k), 0);
            @(negedge clk);
            reset = 1'b0;
            dones = 0;
            repeat (LATENCY + 20) begin
                @(posedge clk);
                #1;
                if (done) dones++;
            end
            check({name, ".abort_no_done"}, dones, 0);
            check({name, ".abort_idle"}, busy, 0);
            void'(sb.pop_front());
            prev_fc = '0;
        end else if (!seen) begin
            check({name, ".timeout"}, 0, 1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check({name, ".latency"}, n, LATENCY);
            check({name, ".busy_in_done"}, busy, 1);
            for (int i = 0; i < FL; i++)
                check({name, ".feat"}, feat_out[i*DW +: DW], e.feat[i*DW +: DW]);
            for (int k = 0; k < NC; k++)
                check({name, ".fc"}, fc_el(fc_out, k), fc_el(e.fc, k));
            check({name, ".class_idx"}, class_idx, e.cls);
            prev_fc = e.fc;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check({name, ".done_pulse"}, done, 0);
            check({name, ".busy_after"}, busy, 0);
            dones = 0;
            repeat (30) begin
                @(posedge clk);
                #1;
                if (done || busy) dones++;
            end
            check({name, ".no_extra_run"}, dones, 0);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        prev_fc    = '0;
        reset      = 1'b1;
        start      = 1'b0;
        cnn_ifmap  = '0;
        weights    = '0;
        fc_weights = '0;
        fc_bias    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.class_idx", class_idx, 0);
        check("reset.fc_out", longint'(fc_out != '0), 0);
        check("reset.feat_out", longint'(feat_out != '0), 0);
        @(negedge clk);
        reset = 1'b0;

        // Zero ifmap: features vanish, logits equal the biases.
        cnn_ifmap = '0;
        for (int i = 0; i < NF*K*K; i++) weights[i*DW +: DW] = DW'($urandom);
        for (int i = 0; i < NC*FL; i++) fc_weights[i*DW +: DW] = DW'($urandom);
        bv = '{5, -3, 7, 0, 0};
        set_bias();
        run_case("zero_ifmap", -1, -1);

        // Equal maxima at classes 1 and 4.
        bv = '{0, 9, -2, 3, 9};
        set_bias();
        run_case("tie", -1, -1);

        // Centre-tap kernels scale a flat map of ones by f+1.
        for (int i = 0; i < IMG*IMG; i++) cnn_ifmap[i*DW +: DW] = 8'd1;
        weights = '0;
        for (int f = 0; f < NF; f++) weights[(f*K*K + (K*K)/2)*DW +: DW] = DW'(f + 1);
        for (int i = 0; i < NC*FL; i++) fc_weights[i*DW +: DW] = 8'd1;
        bv = '{0, 0, 0, 0, 0};
        set_bias();
        run_case("ones", -1, -1);

        // Full-scale unsigned feature against most negative weight.
        for (int i = 0; i < IMG*IMG; i++) cnn_ifmap[i*DW +: DW] = 8'd255;
        weights = '0;
        for (int f = 0; f < NF; f++) weights[(f*K*K + (K*K)/2)*DW +: DW] = 8'd1;
        for (int i = 0; i < NC*FL; i++) fc_weights[i*DW +: DW] = 8'h80;
        run_case("sign", -1, -1);

        // Random data with a stray start during the third filter's conv.
        for (int i = 0; i < IMG*IMG; i++) cnn_ifmap[i*DW +: DW] = DW'($urandom_range(0, 40));
        for (int i = 0; i < NF*K*K; i++) weights[i*DW +: DW] = DW'($urandom);
        for (int i = 0; i < NC*FL; i++) fc_weights[i*DW +: DW] = DW'($urandom);
        for (int k = 0; k < NC; k++) bv[k] = $urandom_range(0, 600) - 300;
        set_bias();
        run_case("restart", 2*PER_FILT + 3, -1);

        // Reset in the middle of FC_MAC, then a clean run on the same data.
        run_case("abort", -1, NF*PER_FILT + 20);
        run_case("after_abort", -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
